// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes A - B LSB first, one bit per clock.
// D = {borrow, difference}, matching the ripple adder's (WIDTH+1)-bit result layout.
//
// state | meaning
// IDLE  | ready; accepts start and captures A/B
// SHIFT | one full-subtractor step per edge, LSB first
// DONE  | one-cycle done pulse; D holds the new result
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   D
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    bits_left;

  logic             a_bit;
  logic             b_bit;
  logic             diff;
  logic             bout;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    a_bit   = a_sr[0];
    b_bit   = b_sr[0];
    diff    = a_bit ^ b_bit ^ borrow;
    bout    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    res_nxt = {diff, res_sr};
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow    <= 1'b0;
      bits_left <= '0;
      D         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr      <= A;
            b_sr      <= B;
            res_sr    <= '0;
            borrow    <= 1'b0;
            bits_left <= CW'(WIDTH - 1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          res_sr    <= res_nxt[WIDTH-1:1];
          borrow    <= bout;
          bits_left <= bits_left - CW'(1);
          // D is only written here so partial results never leak out
          if (bits_left == '0) begin
            D     <= {bout, res_nxt};
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
